// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
package addsub_pkg;

    localparam int W_DEF = 5;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_datapath.sv
// Combinational W-bit ripple add/subtract.
// Subtraction is X + ~Y + 1, and e is the borrow (inverted carry-out).
module addsub_datapath
    import addsub_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         op,
    output logic [W-1:0] s,
    output logic         e
);

    logic [W:0]   c;
    logic [W-1:0] yb;

    always_comb begin
        c    = '0;
        s    = '0;
        yb   = y ^ {W{op}};
        c[0] = op;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ yb[i] ^ c[i];
            c[i+1] = (x[i] & yb[i]) | (x[i] & c[i]) | (yb[i] & c[i]);
        end
        e = (op == OP_SUB) ? ~c[W] : c[W];
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath between two requesters.
//   state | meaning
//   IDLE  | grant one valid requester, latch its operands
//   EXEC  | datapath evaluates latched operands, result registered
//   RESP  | response held until rsp_ready
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    input  logic         req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    input  logic         req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_s,
    output logic         rsp_e
);

    state_t       state, state_nxt;
    logic         rr_ptr;
    logic         grant0, grant1;
    logic [W-1:0] x_q, y_q;
    logic         op_q, id_q;
    logic [W-1:0] dp_s;
    logic         dp_e;

    // A lone valid requester wins regardless of rr_ptr; rr_ptr only breaks ties.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        state_nxt = state;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        case (state)
            IDLE:    if (grant0 || grant1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= 1'b0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= '0;
            rsp_e     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        x_q    <= req0_x;
                        y_q    <= req0_y;
                        op_q   <= req0_op;
                        id_q   <= 1'b0;
                        rr_ptr <= 1'b1;
                    end else if (grant1) begin
                        x_q    <= req1_x;
                        y_q    <= req1_y;
                        op_q   <= req1_op;
                        id_q   <= 1'b1;
                        rr_ptr <= 1'b0;
                    end
                end
                EXEC: begin
                    rsp_s     <= dp_s;
                    rsp_e     <= dp_e;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    addsub_datapath #(.W(W)) u_datapath (
        .x  (x_q),
        .y  (y_q),
        .op (op_q),
        .s  (dp_s),
        .e  (dp_e)
    );

endmodule
